// File: rtl/uart_tx_buffered_if.sv
// Byte write handshake between the CPU UART store path and the buffered transmitter.
interface uart_tx_buffered_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (
        output DataIn,
        output DataInValid,
        input  DataInReady
    );

    modport slave (
        input  DataIn,
        input  DataInValid,
        output DataInReady
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer.
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH      = 8
) (
    input  logic                       CLK,
    input  logic                       reset,
    uart_tx_buffered_if.slave          s_in,
    output logic                       SOut,
    output logic                       TxBusy,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int BCW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW         = $clog2(DEPTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [BCW-1:0]  r_bit_cnt;
    logic [BCW-1:0]  w_bit_cnt_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_sout;
    logic            w_sout_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_ready;
    logic            w_bit_end;
    logic            w_have_data;

    assign w_ready     = (r_count != FULL_CNT);
    assign w_push      = s_in.DataInValid && w_ready;
    assign w_bit_end   = (r_bit_cnt == BIT_LAST);
    assign w_have_data = (r_count != '0);

    assign s_in.DataInReady = w_ready;
    assign SOut             = r_sout;
    assign TxBusy           = (r_state != S_IDLE);
    assign Count            = r_count;

    // Next-state, pop decision and next line level for the serializer.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bit_cnt_nxt = '0;
                if (w_have_data) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    // Next frame starts on this edge so frames abut with no idle cycle.
                    if (w_have_data) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_START: w_sout_nxt = 1'b0;
            S_DATA:  w_sout_nxt = w_shift_nxt[0];
            default: w_sout_nxt = 1'b1;
        endcase
    end

    // Serializer state, bit timing and registered line output.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_sout    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_sout    <= w_sout_nxt;
        end
    end

    // Shift register holds frame payload only; its value is irrelevant while idle.
    always_ff @(posedge CLK) begin
        r_shift <= w_shift_nxt;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_in.DataIn;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level reference model plus line decoder and directed cases.
module tb_uart_tx_buffered;

    localparam int BC    = 10;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * BC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sout;
    logic       busy;
    logic [3:0] count;

    uart_tx_buffered_if tif ();

    uart_tx_buffered #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK   (clk),
        .reset (rst_n),
        .s_in  (tif),
        .SOut  (sout),
        .TxBusy(busy),
        .Count (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_cur = 8'h00;

    function automatic logic line_level(input logic [7:0] b, input int pos);
        int k;
        k = pos / BC;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        int  pre;
        bit  do_push;
        bit  do_pop;
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            return;
        end
        pre     = mq.size();
        do_push = tif.DataInValid && (pre != DEPTH);
        do_pop  = (pre != 0) && (!m_active || m_pos == FRAME - 1);
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 1'b0;
        end
        if (do_pop) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (do_push) mq.push_back(tif.DataIn);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_sout",  {31'd0, sout},  {31'd0, (m_active ? line_level(m_cur, m_pos) : 1'b1)});
                chk("model_busy",  {31'd0, busy},  {31'd0, m_active});
                chk("model_count", {28'd0, count}, mq.size());
                chk("model_ready", {31'd0, tif.DataInReady}, {31'd0, (mq.size() != DEPTH)});
            end
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_q[$];
    int         starts[$];
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;

    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (!rst_n || !chk_en) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (sout === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                    starts.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= BC + BC / 2 && ((rx_cnt - BC / 2) % BC) == 0) begin
                    k = (rx_cnt - BC / 2) / BC;
                    if (k <= 8) begin
                        rx_byte[k-1] = sout;
                    end else begin
                        if (sout === 1'b1) rx_q.push_back(rx_byte);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] b);
        tif.DataIn      = b;
        tif.DataInValid = 1'b1;
        @(negedge clk);
        tif.DataInValid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((count !== 4'd0 || busy !== 1'b0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, (k < limit)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed cases ----------------
    initial begin
        int n;
        int s;
        int idx;
        int k;
        int maxc;

        tif.DataIn      = 8'h77;
        tif.DataInValid = 1'b1;
        rst_n           = 1'b0;

        // Reset with a write strobe held high.
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sout",  {31'd0, sout}, 32'd1);
        chk("rst_ready", {31'd0, tif.DataInReady}, 32'd1);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        tif.DataInValid = 1'b0;
        rst_n           = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_nothing_queued", {28'd0, count}, 32'd0);
        chk("rst_no_frame", rx_q.size() + starts.size(), 32'd0);

        // Single byte 0xA5.
        rx_q.delete();
        starts.delete();
        push(8'hA5);
        n = cyc;
        chk("single_count_after_push", {28'd0, count}, 32'd1);
        wait_cyc(n + 1);
        chk("single_start_sout", {31'd0, sout}, 32'd0);
        chk("single_start_busy", {31'd0, busy}, 32'd1);
        wait_cyc(n + 10);
        chk("single_start_end", {31'd0, sout}, 32'd0);
        wait_cyc(n + 11);
        chk("single_bit0", {31'd0, sout}, 32'd1);
        wait_cyc(n + 21);
        chk("single_bit1", {31'd0, sout}, 32'd0);
        wait_cyc(n + 41);
        chk("single_bit3", {31'd0, sout}, 32'd0);
        wait_cyc(n + 61);
        chk("single_bit5", {31'd0, sout}, 32'd1);
        wait_cyc(n + 81);
        chk("single_bit7", {31'd0, sout}, 32'd1);
        wait_cyc(n + 91);
        chk("single_stop", {31'd0, sout}, 32'd1);
        wait_cyc(n + 100);
        chk("single_busy_last", {31'd0, busy}, 32'd1);
        wait_cyc(n + 101);
        chk("single_busy_fall", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("single_rx_len", rx_q.size(), 32'd1);
        if (rx_q.size() >= 1) chk("single_rx_byte", {24'd0, rx_q[0]}, 32'hA5);

        // Fill the FIFO and attempt an overflow.
        rx_q.delete();
        starts.delete();
        for (int i = 0; i < 10; i++) begin
            tif.DataIn      = 8'(i);
            tif.DataInValid = 1'b1;
            @(negedge clk);
            if (i == 8) begin
                chk("fill_count_full", {28'd0, count}, 32'd8);
                chk("fill_ready_low",  {31'd0, tif.DataInReady}, 32'd0);
            end
        end
        tif.DataInValid = 1'b0;
        chk("fill_overflow_ignored", {28'd0, count}, 32'd8);
        wait_idle(2000);
        chk("fill_rx_len", rx_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) chk("fill_rx_byte", {24'd0, rx_q[i]}, i);
        end

        // Back-to-back frames.
        rx_q.delete();
        starts.delete();
        push(8'h55);
        push(8'h0F);
        wait_idle(1000);
        chk("b2b_frames", starts.size(), 32'd2);
        if (starts.size() >= 2) chk("b2b_spacing", starts[1] - starts[0], 32'd100);
        chk("b2b_rx_len", rx_q.size(), 32'd2);
        if (rx_q.size() >= 2) begin
            chk("b2b_rx0", {24'd0, rx_q[0]}, 32'h55);
            chk("b2b_rx1", {24'd0, rx_q[1]}, 32'h0F);
        end

        // Reset during data bit 3 with bytes still queued.
        push(8'hC3);
        n = cyc;
        push(8'h3C);
        push(8'hAA);
        s = n + 1;
        wait_cyc(s + 44);
        chk("midrst_count_before", {28'd0, count}, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sout",  {31'd0, sout}, 32'd1);
        chk("midrst_count", {28'd0, count}, 32'd0);
        chk("midrst_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        starts.delete();
        repeat (300) @(negedge clk);
        chk("midrst_no_residual", rx_q.size() + starts.size(), 32'd0);
        chk("midrst_line_high", {31'd0, sout}, 32'd1);

        // Stream 20 bytes through the wrapping pointers.
        rx_q.delete();
        starts.delete();
        idx  = 0;
        k    = 0;
        maxc = 0;
        while (idx < 20 && k < 5000) begin
            if (tif.DataInReady === 1'b1) begin
                tif.DataIn      = 8'(8'h30 + idx);
                tif.DataInValid = 1'b1;
                idx++;
            end else begin
                tif.DataInValid = 1'b0;
            end
            @(negedge clk);
            k++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        tif.DataInValid = 1'b0;
        chk("wrap_all_pushed", idx, 32'd20);
        chk("wrap_count_max", {31'd0, (maxc <= 8)}, 32'd1);
        wait_idle(5000);
        chk("wrap_rx_len", rx_q.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < rx_q.size()) chk("wrap_rx_byte", {24'd0, rx_q[i]}, 32'h30 + i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter directly downstream of the CPU datapath's UART store path. It accepts bytes on the `DataIn`/`DataInValid`/`DataInReady` handshake the datapath drives on UART stores, and queues them in a small FIFO. A serializer drains the FIFO onto the serial line as 8N1 frames. `DataInReady` is also the status bit the datapath reads back through its UART status select.

## Interface
Parameters:
- `CLOCK_FREQ`, 33_000_000: core clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `CLK`  in  1  core clock; all state changes on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low (`reset == 0` resets on a rising `CLK` edge).
- `DataIn`  in  8  byte to transmit.
- `DataInValid`  in  1  write strobe; one cycle per byte.
- `DataInReady`  out  1  FIFO not full.
- `SOut`  out  1  serial line; idles high.
- `TxBusy`  out  1  serializer mid-frame.
- `Count`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- **Bit period.** `BIT_CYCLES = CLOCK_FREQ / BAUD_RATE`, integer floor (286 at the defaults).
  - A bit counter of width $clog2(BIT_CYCLES) counts 0..BIT_CYCLES-1.
- **Push.** A push occurs on an edge where `DataInValid && DataInReady`.
  - `DataInValid` while full is ignored: no state change, byte dropped.
- **FIFO.** Circular buffer with write/read pointers of width $clog2(DEPTH); pointers wrap modulo `DEPTH`.
  - `Count` is a register.
  - `DataInReady = (Count != DEPTH)`, combinational from `Count`.
- **Push and pop on the same edge.** `Count` is unchanged; both pointers advance.
  - When full, a pop frees one entry, but `DataInReady` rises only after that edge.
- **Serializer states.** IDLE, START, DATA, STOP; shift register 8 bits; bit index 0..7.
  - IDLE: `SOut` = 1. If `Count != 0`: pop the head into the shift register, clear the bit counter, go to START.
  - START: `SOut` = 0 for `BIT_CYCLES` cycles, then DATA with bit index 0.
  - DATA: `SOut` = shift[0], LSB first. Each bit lasts `BIT_CYCLES` cycles, then shift right. After bit 7, go to STOP.
  - STOP: `SOut` = 1 for `BIT_CYCLES` cycles. At the final edge, if `Count != 0`, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- **Outputs.** `SOut` is registered and driven from state and shift register. `TxBusy = (state != IDLE)`.
- **Frame length.** Exactly 10 × `BIT_CYCLES` cycles; consecutive frames abut.

## Timing
- **Reset values.** `SOut` = 1, `DataInReady` = 1, `TxBusy` = 0, `Count` = 0.
  - State IDLE; pointers 0; FIFO contents don't-care.
- **Reset mid-frame.** The line returns high on the reset edge. The queued bytes are discarded and no partial frame resumes.
- **Push latency (FIFO empty, serializer IDLE):**
  - Push at edge N makes `Count` = 1 after N.
  - Pop at edge N+1, which sets `SOut` = 0 and `TxBusy` = 1 after N+1.
  - `TxBusy` falls after edge N+1+10×`BIT_CYCLES` if no further data.
- **`Count` update.** Changes only on push/pop edges: +1 on push only, −1 on pop only.
- **No underflow/overflow.** A pop never occurs when `Count == 0`; a push never occurs when `Count == DEPTH`.

## Test plan
Sim parameters: `CLOCK_FREQ` = 1000, `BAUD_RATE` = 100 (`BIT_CYCLES` = 10), `DEPTH` = 8.

1. **Reset.** Hold `reset` = 0 for 3 edges with `DataInValid` = 1 → `SOut` = 1, `DataInReady` = 1, `Count` = 0, `TxBusy` = 0; nothing queued.
2. **Single byte.** Push 0xA5 at edge N →
   - `SOut` 0 over cycles N+1..N+10;
   - bits 1,0,1,0,0,1,0,1, each 10 cycles, over N+11..N+90;
   - 1 over N+91..N+100;
   - `TxBusy` 0 after N+101.
3. **Fill and overflow.** Push 0x00..0x08 on 9 consecutive edges (serializer pops 0x00 one edge after its push) → `Count` = 8 and `DataInReady` = 0. A 10th push of 0x09 is ignored. The line carries 0x00..0x08 in order and 0x09 never appears.
4. **Back-to-back frames.** Push 0x55 then 0x0F →
   - stop bit of frame 1 is followed immediately by the start bit of frame 2;
   - start-bit falling edges exactly 100 cycles apart.
5. **Reset mid-frame.** 3 bytes queued; assert `reset` during DATA bit 3 → `SOut` = 1, `Count` = 0, `TxBusy` = 0 after that edge. After release, the line stays high with no residual frames.
6. **Pointer wrap.** Stream 20 bytes 0x30..0x43, pushing whenever `DataInReady` = 1 → all 20 received in order. `Count` never exceeds 8 or goes below 0.
